// File: rtl/quad2joy_if.sv
// Steering link bus: sampled quadrature pins, ce/clr controls and decoded outputs.
// master drives pins/controls and reads results; slave is the decoder.
interface quad2joy_if #(
  parameter int CNT_W = 8
);
  logic             ce;
  logic             quadA;
  logic             quadB;
  logic             clr;
  logic [CNT_W-1:0] position;
  logic             step;
  logic             dir;
  logic             right;
  logic             left;
  logic             error;

  modport master (
    output ce, quadA, quadB, clr,
    input  position, step, dir, right, left, error
  );

  modport slave (
    input  ce, quadA, quadB, clr,
    output position, step, dir, right, left, error
  );
endinterface

// File: rtl/quad2joy.sv
// Quadrature steering decoder: sync, glitch filter, step decode, held levels.
// Ports: CLK, Reset_n (async low), bus (ce/quadA/quadB/clr in; position/step/dir/right/left/error out).
module quad2joy #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int CNT_W       = 8,
  parameter int PULSE_HOLD  = 22500
) (
  input  logic       CLK,
  input  logic       Reset_n,
  quad2joy_if.slave  bus
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int HW = $clog2(PULSE_HOLD + 1);

  logic [SYNC_STAGES-1:0] a_sync;
  logic [SYNC_STAGES-1:0] b_sync;
  logic [1:0]             pair;

  logic [1:0]    pair_q;
  logic [FW-1:0] flt_cnt;
  logic [FW-1:0] cnt_nxt;
  logic [1:0]    filt;
  logic          changed;

  logic [1:0]       state;
  logic             init;
  logic             both;
  logic             fwd;
  logic             dec_step;
  logic             dec_err;
  logic             dec_right;

  logic [CNT_W-1:0] position_q;
  logic             step_q;
  logic             dir_q;
  logic             error_q;
  logic             right_q;
  logic             left_q;
  logic [HW-1:0]    hold_cnt;

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      a_sync <= '0;
      b_sync <= '0;
    end else begin
      a_sync <= {a_sync[SYNC_STAGES-2:0], bus.quadA};
      b_sync <= {b_sync[SYNC_STAGES-2:0], bus.quadB};
    end
  end

  assign pair = {a_sync[SYNC_STAGES-1], b_sync[SYNC_STAGES-1]};

  // A new pair counts as its own first sample.
  assign changed = pair != pair_q;
  assign cnt_nxt = changed ? FW'(1) : flt_cnt + FW'(1);

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      pair_q  <= '0;
      flt_cnt <= '0;
      filt    <= '0;
    end else if (bus.ce) begin
      pair_q <= pair;
      if (pair == filt) begin
        flt_cnt <= '0;
      end else if (cnt_nxt == FW'(FILTER_LEN)) begin
        flt_cnt <= '0;
        filt    <= pair;
      end else begin
        flt_cnt <= cnt_nxt;
      end
    end
  end

  // Gray index along the right sequence 00,01,11,10.
  function automatic logic [1:0] gidx(input logic [1:0] s);
    return {s[1], s[1] ^ s[0]};
  endfunction

  assign both = &(filt ^ state);
  assign fwd  = gidx(filt) == gidx(state) + 2'd1;

  always_comb begin
    dec_step  = 1'b0;
    dec_err   = 1'b0;
    dec_right = 1'b0;
    if (filt != state) begin
      unique case (1'b1)
        init: begin
        end
        !init && both: begin
          dec_err = 1'b1;
        end
        !init && !both && fwd: begin
          dec_step  = 1'b1;
          dec_right = 1'b1;
        end
        default: begin
          dec_step = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= '0;
      init       <= 1'b1;
      position_q <= '0;
      step_q     <= 1'b0;
      dir_q      <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      step_q  <= 1'b0;
      error_q <= 1'b0;
      if (bus.ce) begin
        if (filt != state) begin
          state <= filt;
          init  <= 1'b0;
        end
        if (dec_step) begin
          step_q     <= 1'b1;
          dir_q      <= dec_right;
          position_q <= dec_right ? position_q + CNT_W'(1)
                                  : position_q - CNT_W'(1);
        end
        if (dec_err) begin
          error_q <= 1'b1;
        end
        // clr overrides a coincident step's count.
        if (bus.clr) begin
          position_q <= '0;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      hold_cnt <= '0;
      right_q  <= 1'b0;
      left_q   <= 1'b0;
    end else if (bus.ce) begin
      if (dec_step) begin
        hold_cnt <= HW'(PULSE_HOLD);
        right_q  <= dec_right;
        left_q   <= !dec_right;
      end else if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - HW'(1);
        if (hold_cnt == HW'(1)) begin
          right_q <= 1'b0;
          left_q  <= 1'b0;
        end
      end
    end
  end

  assign bus.position = position_q;
  assign bus.step     = step_q;
  assign bus.dir      = dir_q;
  assign bus.error    = error_q;
  assign bus.right    = right_q;
  assign bus.left     = left_q;

endmodule

// File: tb/tb_quad2joy.sv
// Scoreboard bench for quad2joy: model predicts step/error events per pin change.
// Ports exercised through quad2joy_if; small PULSE_HOLD to observe hold timing.
module tb_quad2joy;

  logic clk_sys = 1'b0;
  logic rst_n;

  always #5 clk_sys = ~clk_sys;

  quad2joy_if #(.CNT_W(8)) bus();

  quad2joy #(
    .SYNC_STAGES(2),
    .FILTER_LEN(4),
    .CNT_W(8),
    .PULSE_HOLD(5)
  ) dut (
    .CLK(clk_sys),
    .Reset_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    int         kind;
    logic       dir;
    logic [7:0] pos;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   passes = 0;

  logic [1:0] mst;
  bit         minit;
  logic [7:0] mpos;
  logic       mdir;

  function automatic logic [1:0] gi(input logic [1:0] s);
    return {s[1], s[1] ^ s[0]};
  endfunction

  task automatic expect_move(input logic [1:0] p, input bit clr_hit);
    exp_t e;
    if (p == mst) return;
    if (minit) begin
      minit = 0;
    end else if ((p ^ mst) == 2'b11) begin
      e.kind = 2; e.dir = mdir; e.pos = mpos;
      sbq.push_back(e);
    end else begin
      if (gi(p) == gi(mst) + 2'd1) begin
        mpos = mpos + 8'd1; mdir = 1'b1;
      end else begin
        mpos = mpos - 8'd1; mdir = 1'b0;
      end
      if (clr_hit) mpos = 8'd0;
      e.kind = 1; e.dir = mdir; e.pos = mpos;
      sbq.push_back(e);
    end
    mst = p;
  endtask

  task automatic set_pins(input logic [1:0] p, input bit clr_hit);
    {bus.quadA, bus.quadB} = p;
    expect_move(p, clr_hit);
  endtask

  // Steps n cycles, popping the scoreboard on every step/error pulse.
  task automatic run(input int n, input int clr_edge,
                     output int first_ev, output int rcnt, output int lcnt);
    exp_t e;
    int   got;
    bit   both_hi;
    first_ev = 0; rcnt = 0; lcnt = 0; both_hi = 0;
    for (int k = 1; k <= n; k++) begin
      bus.clr = (k == clr_edge);
      @(posedge clk_sys); #1;
      if (bus.right) rcnt++;
      if (bus.left) lcnt++;
      if (bus.right && bus.left) both_hi = 1;
      if (bus.step || bus.error) begin
        got = (bus.step ? 1 : 0) + (bus.error ? 2 : 0);
        checks++;
        if (sbq.size() == 0) begin
          $display("FAIL unexpected_pulse edge %0d: got kind %0d pos %0d, required no pulse",
                   k, got, bus.position);
        end else begin
          e = sbq.pop_front();
          if (first_ev == 0) first_ev = k;
          if (got !== e.kind || bus.dir !== e.dir || bus.position !== e.pos)
            $display("FAIL event: got kind %0d dir %0b pos %0d, required kind %0d dir %0b pos %0d",
                     got, bus.dir, bus.position, e.kind, e.dir, e.pos);
          else passes++;
        end
      end
    end
    bus.clr = 1'b0;
    checks++;
    if (sbq.size() != 0) begin
      $display("FAIL timeout: %0d expected events not seen", sbq.size());
      sbq.delete();
    end else if (both_hi) begin
      $display("FAIL levels: right and left both 1, required exclusive");
    end else passes++;
  endtask

  task automatic do_reset(input logic [1:0] p);
    rst_n = 1'b0;
    bus.ce = 1'b1; bus.clr = 1'b0;
    {bus.quadA, bus.quadB} = p;
    repeat (3) @(posedge clk_sys);
    #1;
    mst = 2'b00; minit = 1; mpos = 8'd0; mdir = 1'b0;
    sbq.delete();
    rst_n = 1'b1;
    expect_move(p, 0);
  endtask

  task automatic do_clr();
    bus.clr = 1'b1;
    @(posedge clk_sys); #1;
    bus.clr = 1'b0;
    mpos = 8'd0;
    checks++;
    if (bus.position !== 8'd0)
      $display("FAIL clr: position %0d, required 0", bus.position);
    else passes++;
  endtask

  task automatic test_reset();
    int ev, rc, lc;
    do_reset(2'b11);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.position, bus.step, bus.dir, bus.right, bus.left, bus.error} !== 13'd0)
      $display("FAIL reset_outputs: got %h, required 0",
               {bus.position, bus.step, bus.dir, bus.right, bus.left, bus.error});
    else passes++;
    rst_n = 1'b1;
    run(10, 0, ev, rc, lc);
    checks++;
    if (ev !== 0 || bus.position !== 8'd0)
      $display("FAIL init_adopt: event edge %0d pos %0d, required none and 0", ev, bus.position);
    else passes++;
  endtask

  task automatic test_right_seq();
    int ev, rc, lc, nsteps;
    logic [1:0] seq [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
    set_pins(2'b10, 0); run(8, 0, ev, rc, lc);
    set_pins(2'b00, 0); run(8, 0, ev, rc, lc);
    do_clr();
    nsteps = 0;
    for (int i = 0; i < 4; i++) begin
      set_pins(seq[i], 0);
      run(8, 0, ev, rc, lc);
      if (ev != 0) nsteps++;
      if (i == 0) begin
        checks++;
        if (ev !== 7) $display("FAIL latency: step at edge %0d, required 7", ev);
        else passes++;
      end
    end
    checks++;
    if (nsteps !== 4 || bus.position !== 8'd4 || bus.dir !== 1'b1)
      $display("FAIL right_seq: steps %0d pos %0d dir %0b, required 4 4 1",
               nsteps, bus.position, bus.dir);
    else passes++;
  endtask

  task automatic test_glitch();
    int ev1, ev2, rc, lc;
    bus.quadA = 1'b1;
    run(3, 0, ev1, rc, lc);
    bus.quadA = 1'b0;
    run(8, 0, ev2, rc, lc);
    checks++;
    if (ev1 !== 0 || ev2 !== 0 || bus.position !== 8'd4)
      $display("FAIL glitch: events %0d/%0d pos %0d, required none and 4",
               ev1, ev2, bus.position);
    else passes++;
  endtask

  task automatic test_illegal();
    int ev, rc, lc;
    set_pins(2'b11, 0); run(8, 0, ev, rc, lc);
    checks++;
    if (ev !== 7 || bus.position !== 8'd4)
      $display("FAIL illegal: error edge %0d pos %0d, required 7 and 4", ev, bus.position);
    else passes++;
    set_pins(2'b10, 0); run(8, 0, ev, rc, lc);
    checks++;
    if (bus.position !== 8'd5)
      $display("FAIL after_illegal: pos %0d, required 5", bus.position);
    else passes++;
  endtask

  task automatic test_wrap();
    int ev, rc, lc;
    do_clr();
    set_pins(2'b11, 0); run(8, 0, ev, rc, lc);
    checks++;
    if (bus.position !== 8'd255) $display("FAIL wrap_down: pos %0d, required 255", bus.position);
    else passes++;
    set_pins(2'b10, 0); run(8, 0, ev, rc, lc);
    checks++;
    if (bus.position !== 8'd0) $display("FAIL wrap_up: pos %0d, required 0", bus.position);
    else passes++;
    set_pins(2'b11, 0); run(8, 0, ev, rc, lc);
    set_pins(2'b10, 1); run(8, 7, ev, rc, lc);
    checks++;
    if (ev !== 7 || bus.position !== 8'd0)
      $display("FAIL clr_step: step edge %0d pos %0d, required 7 and 0", ev, bus.position);
    else passes++;
  endtask

  task automatic test_ce_freeze();
    int ev, rc, lc, pulses;
    bus.ce = 1'b0;
    set_pins(2'b00, 0);
    pulses = 0;
    repeat (20) begin
      @(posedge clk_sys); #1;
      if (bus.step || bus.error) pulses++;
    end
    checks++;
    if (pulses !== 0 || bus.position !== 8'd0)
      $display("FAIL ce_freeze: pulses %0d pos %0d, required 0 0", pulses, bus.position);
    else passes++;
    bus.ce = 1'b1;
    run(8, 0, ev, rc, lc);
    checks++;
    if (ev !== 5) $display("FAIL ce_resume: step edge %0d, required 5", ev);
    else passes++;
  endtask

  task automatic test_hold();
    int   ev, rc, lc;
    exp_t e;
    logic prev_r;
    do_reset(2'b10);
    run(10, 0, ev, rc, lc);
    set_pins(2'b00, 0);
    run(16, 0, ev, rc, lc);
    checks++;
    if (rc !== 5 || lc !== 0)
      $display("FAIL hold_len: right %0d left %0d cycles, required 5 0", rc, lc);
    else passes++;
    set_pins(2'b01, 0);
    prev_r = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (k == 5) set_pins(2'b00, 0);
      @(posedge clk_sys); #1;
      if (bus.step) begin
        checks++;
        if (sbq.size() == 0) begin
          $display("FAIL hold_pulse: unexpected step at edge %0d", k);
        end else begin
          e = sbq.pop_front();
          if (bus.dir !== e.dir || bus.position !== e.pos)
            $display("FAIL hold_event: dir %0b pos %0d, required %0b %0d",
                     bus.dir, bus.position, e.dir, e.pos);
          else passes++;
        end
        if (!bus.dir) begin
          checks++;
          if (k !== 11 || prev_r !== 1'b1 || bus.right !== 1'b0 || bus.left !== 1'b1)
            $display("FAIL switch: edge %0d prev_r %0b r %0b l %0b, required 11 1 0 1",
                     k, prev_r, bus.right, bus.left);
          else passes++;
        end
      end
      prev_r = bus.right;
    end
    checks++;
    if (sbq.size() != 0 || bus.left !== 1'b1) begin
      $display("FAIL hold_mid: pending %0d left %0b, required 0 1", sbq.size(), bus.left);
      sbq.delete();
    end else passes++;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.left !== 1'b0 || bus.right !== 1'b0 || bus.position !== 8'd0)
      $display("FAIL async_reset: l %0b r %0b pos %0d, required 0 0 0",
               bus.left, bus.right, bus.position);
    else passes++;
    repeat (2) @(posedge clk_sys);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.ce = 1'b1;
    bus.clr = 1'b0;
    bus.quadA = 1'b0;
    bus.quadB = 1'b0;
    test_reset();
    test_right_seq();
    test_glitch();
    test_illegal();
    test_wrap();
    test_ce_freeze();
    test_hold();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
